// File: rtl/program_counter_stack.sv
// program_counter_stack: program counter with an integrated return-address stack.
// Each enabled edge performs one action, priority ret > call > jump > rel > increment.
// Optional feature macro: PC_REL_BRANCH_EN (PC-relative branch adder).
module program_counter_stack #(
   parameter int                  PC_WIDTH     = 8,
   parameter int                  STACK_DEPTH  = 4,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                               clk,
   input  logic                               res_n,
   input  logic                               en,
   input  logic                               wr_en,
   input  logic [PC_WIDTH-1:0]                counteradress,
   input  logic                               call_en,
   input  logic                               ret_en,
   input  logic                               rel_en,
   input  logic [PC_WIDTH-1:0]                rel_offset,
   output logic [PC_WIDTH-1:0]                pc,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
   output logic                               stack_empty,
   output logic                               stack_full,
   output logic                               stack_err
);

   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [DW-1:0]       depth_q, depth_d;
   logic                err_q, err_d;
   logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

   logic                push_en;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [DW-1:0]       top_idx;
   logic                empty, full;

   assign pc_inc  = pc_q + PC_WIDTH'(1);
   assign top_idx = depth_q - DW'(1);
   assign empty   = (depth_q == '0);
   assign full    = (depth_q == DW'(STACK_DEPTH));

`ifdef PC_REL_BRANCH_EN
   logic [PC_WIDTH-1:0] pc_rel;
   // offset is relative to the current pc, not pc+1
   assign pc_rel = pc_q + rel_offset;
`else
   // relative branch not built; inputs kept on the port list only
   logic unused_rel;
   assign unused_rel = ^{rel_en, rel_offset};
`endif

   // next-state: one prioritized action per enabled edge; error cases hold pc/depth
   always_comb begin
      pc_d    = pc_q;
      depth_d = depth_q;
      err_d   = err_q;
      push_en = 1'b0;
      if (en) begin
         if (ret_en) begin
            if (empty) begin
               err_d = 1'b1;
            end else begin
               pc_d    = stack_q[top_idx[AW-1:0]];
               depth_d = top_idx;
            end
         end else if (call_en) begin
            if (full) begin
               err_d = 1'b1;
            end else begin
               push_en = 1'b1;
               pc_d    = counteradress;
               depth_d = depth_q + DW'(1);
            end
         end else if (wr_en) begin
            pc_d = counteradress;
`ifdef PC_REL_BRANCH_EN
         end else if (rel_en) begin
            pc_d = pc_rel;
`endif
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   // control state: pc, depth and the sticky error flag
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         pc_q    <= RESET_VECTOR;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   // stack storage is not reset; writes are blocked while reset is held
   always_ff @(posedge clk) begin
      if (push_en && res_n) begin
         stack_q[depth_q[AW-1:0]] <= pc_inc;
      end
   end

   assign pc          = pc_q;
   assign depth       = depth_q;
   assign stack_empty = empty;
   assign stack_full  = full;
   assign stack_err   = err_q;

endmodule
